// File: rtl/operand_bank_if.sv
// Operand bank port bundle: operator controls in, operand views and status out.
// Latency: none (wires only).
// Backpressure: none; the button strobes are level signals and are edge-detected downstream.
// Ports: sw/mode select the operand; set_n/clr_n are the raw active-low buttons;
//        from_set is the load value; to_set/leds/operands/ptr/loaded/full/wr_stb are the bank's outputs.
interface operand_bank_if #(
    parameter int BITS = 16,
    parameter int NUM  = 4
);
    localparam int SEL_W = $clog2(NUM);

    logic [SEL_W-1:0]    sw;
    logic                mode;
    logic                set_n;
    logic                clr_n;
    logic [BITS-1:0]     from_set;
    logic [BITS-1:0]     to_set;
    logic [NUM*BITS-1:0] operands;
    logic [9:0]          leds;
    logic [SEL_W-1:0]    ptr;
    logic [NUM-1:0]      loaded;
    logic                full;
    logic                wr_stb;

    // Driver side (board / testbench).
    modport master (
        output sw, mode, set_n, clr_n, from_set,
        input  to_set, operands, leds, ptr, loaded, full, wr_stb
    );

    // Bank side.
    modport slave (
        input  sw, mode, set_n, clr_n, from_set,
        output to_set, operands, leds, ptr, loaded, full, wr_stb
    );
endinterface

// File: rtl/operand_bank.sv
// Bank of NUM operand registers loaded/cleared by debounced-edge button presses.
// Latency: button low at edge k is written at edge k+2; wr_stb is high in the cycle after that edge.
// Backpressure: none; a held button yields exactly one action, and release yields nothing.
// Ports: clk, rst (synchronous, active high) plus the operand_bank_if slave bundle.
//        to_set/leds show the selected operand; operands is the flattened bank (operand i at [i*BITS +: BITS]).
module operand_bank #(
    parameter int BITS = 16,
    parameter int NUM  = 4
) (
    input  logic          clk,
    input  logic          rst,
    operand_bank_if.slave bus
);
    localparam int SEL_W = $clog2(NUM);

    logic [BITS-1:0]  regs [NUM];
    logic [NUM-1:0]   loaded;
    logic [SEL_W-1:0] ptr;
    logic             wr_stb;

    // Two-flop synchronisers plus a history flop for edge detection.
    logic set_s1, set_s2, set_s3;
    logic clr_s1, clr_s2, clr_s3;
    logic set_p, clr_p;

    logic [SEL_W-1:0]  idx;
    logic              idx_ok;
    logic [BITS-1:0]   to_set;
    logic [BITS+9:0]   to_set_ext;

    assign set_p = set_s3 & ~set_s2;
    assign clr_p = clr_s3 & ~clr_s2;

    // Manual select may point past the bank when NUM is not a power of two;
    // such an index reads as zero and ignores the buttons. ptr is always in range.
    assign idx    = bus.mode ? ptr : bus.sw;
    assign idx_ok = (int'(idx) < NUM);

    always_comb begin
        to_set = '0;
        for (int i = 0; i < NUM; i++) begin
            if (idx_ok && (idx == SEL_W'(i))) begin
                to_set = regs[i];
            end
        end
    end

    always_comb begin
        bus.operands = '0;
        for (int i = 0; i < NUM; i++) begin
            bus.operands[i*BITS +: BITS] = regs[i];
        end
    end

    // Zero-extend before taking the LED slice so narrow BITS still works.
    assign to_set_ext = {10'b0, to_set};
    assign bus.leds   = to_set_ext[9:0];
    assign bus.to_set = to_set;
    assign bus.ptr    = ptr;
    assign bus.loaded = loaded;
    assign bus.full   = &loaded;
    assign bus.wr_stb = wr_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync chain reset to "released" so reset never manufactures an edge
            // and any edge already in flight is dropped.
            set_s1 <= 1'b1;
            set_s2 <= 1'b1;
            set_s3 <= 1'b1;
            clr_s1 <= 1'b1;
            clr_s2 <= 1'b1;
            clr_s3 <= 1'b1;
            for (int i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
            loaded <= '0;
            ptr    <= '0;
            wr_stb <= 1'b0;
        end else begin
            set_s1 <= bus.set_n;
            set_s2 <= set_s1;
            set_s3 <= set_s2;
            clr_s1 <= bus.clr_n;
            clr_s2 <= clr_s1;
            clr_s3 <= clr_s2;
            wr_stb <= 1'b0;

            // Clear has priority over set when both edges land together.
            if (idx_ok && clr_p) begin
                wr_stb <= 1'b1;
                if (bus.mode) begin
                    for (int i = 0; i < NUM; i++) begin
                        regs[i] <= '0;
                    end
                    loaded <= '0;
                    ptr    <= '0;
                end else begin
                    for (int i = 0; i < NUM; i++) begin
                        if (idx == SEL_W'(i)) begin
                            regs[i]   <= '0;
                            loaded[i] <= 1'b0;
                        end
                    end
                end
            end else if (idx_ok && set_p) begin
                wr_stb <= 1'b1;
                for (int i = 0; i < NUM; i++) begin
                    if (idx == SEL_W'(i)) begin
                        regs[i]   <= bus.from_set;
                        loaded[i] <= 1'b1;
                    end
                end
                if (bus.mode) begin
                    ptr <= (ptr == SEL_W'(NUM - 1)) ? '0 : ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_operand_bank.sv
// Randomized and directed self-checking bench for operand_bank (NUM=4 main instance, NUM=3 side instance).
// Latency: expectations follow the press-at-edge-k / write-at-edge-k+2 rule.
// Backpressure: n/a.
module tb_operand_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_bank_if #(.BITS(16), .NUM(4)) bus ();
    operand_bank_if #(.BITS(16), .NUM(3)) b3 ();

    operand_bank #(.BITS(16), .NUM(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    operand_bank #(.BITS(16), .NUM(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the bank as plain arrays, updated once per accepted press.
    logic [15:0] m_reg [4];
    logic [3:0]  m_loaded;
    int          m_ptr;
    logic        cur_mode;
    logic [1:0]  cur_sw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_loaded = '0;
        m_ptr    = 0;
    endtask

    task automatic model_op(input bit do_set, input bit do_clr, input bit md,
                            input logic [1:0] s, input logic [15:0] v);
        int idx;
        idx = md ? m_ptr : int'(s);
        if (do_clr) begin
            if (md) begin
                model_reset();
            end else begin
                m_reg[idx]    = '0;
                m_loaded[idx] = 1'b0;
            end
        end else if (do_set) begin
            m_reg[idx]    = v;
            m_loaded[idx] = 1'b1;
            if (md) m_ptr = (m_ptr + 1) % 4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] ops;
        logic [15:0] ts;
        int idx;
        for (int i = 0; i < 4; i++) ops[i*16 +: 16] = m_reg[i];
        idx = cur_mode ? m_ptr : int'(cur_sw);
        ts  = m_reg[idx];
        chk({tag, ".to_set"},   64'(bus.to_set),   64'(ts));
        chk({tag, ".leds"},     64'(bus.leds),     64'(ts[9:0]));
        chk({tag, ".operands"}, bus.operands,      ops);
        chk({tag, ".ptr"},      64'(bus.ptr),      64'(m_ptr));
        chk({tag, ".loaded"},   64'(bus.loaded),   64'(m_loaded));
        chk({tag, ".full"},     64'(bus.full),     64'(&m_loaded));
    endtask

    // Press one or both buttons for 'hold' cycles with the other inputs stable.
    task automatic press(input bit do_set, input bit do_clr, input bit md,
                         input logic [1:0] s, input logic [15:0] v, input int hold);
        @(negedge clk);
        cur_mode     = md;
        cur_sw       = s;
        bus.mode     = md;
        bus.sw       = s;
        bus.from_set = v;
        bus.set_n    = !do_set;
        bus.clr_n    = !do_clr;
        for (int c = 0; c < hold + 4; c++) begin
            @(negedge clk);
            if (c == 2) model_op(do_set, do_clr, md, s, v);
            chk($sformatf("wr_stb.c%0d", c), 64'(bus.wr_stb), 64'((c == 2) && (do_set || do_clr)));
            if (c == 2) check_all("press");
            if (c + 1 >= hold) begin
                bus.set_n = 1'b1;
                bus.clr_n = 1'b1;
            end
        end
    endtask

    task automatic press3(input logic [1:0] s, input logic [15:0] v, input bit do_clr,
                          input bit valid, input logic [47:0] exp_ops);
        @(negedge clk);
        b3.mode     = 1'b0;
        b3.sw       = s;
        b3.from_set = v;
        b3.set_n    = do_clr;
        b3.clr_n    = !do_clr;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("n3.wr_stb.c%0d", c), 64'(b3.wr_stb), 64'((c == 2) && valid));
            if (c == 1) begin
                b3.set_n = 1'b1;
                b3.clr_n = 1'b1;
            end
        end
        chk("n3.operands", 64'(b3.operands), 64'(exp_ops));
        chk("n3.to_set",   64'(b3.to_set),   valid ? 64'(v) : 64'h0);
        chk("n3.leds",     64'(b3.leds),     valid ? 64'(v[9:0]) : 64'h0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.mode     = 1'b0;
        bus.sw       = '0;
        bus.set_n    = 1'b1;
        bus.clr_n    = 1'b1;
        bus.from_set = '0;
        b3.mode      = 1'b0;
        b3.sw        = '0;
        b3.set_n     = 1'b1;
        b3.clr_n     = 1'b1;
        b3.from_set  = '0;
        cur_mode     = 1'b0;
        cur_sw       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.wr_stb", 64'(bus.wr_stb), 64'h0);
        check_all("reset");

        // Manual load of operand 2 with a long hold.
        press(1, 0, 0, 2'd2, 16'h1234, 5);
        chk("t1.loaded", 64'(bus.loaded), 64'h4);
        chk("t1.leds",   64'(bus.leds),   64'h234);

        // Auto-sequence fills the bank and wraps the pointer.
        press(0, 1, 1, 2'd0, 16'h0, 1);
        press(1, 0, 1, 2'd0, 16'h0011, 2);
        press(1, 0, 1, 2'd0, 16'h0022, 1);
        press(1, 0, 1, 2'd0, 16'h0033, 3);
        press(1, 0, 1, 2'd0, 16'h0044, 2);
        chk("t2.operands", bus.operands, 64'h0044_0033_0022_0011);
        chk("t2.full",     64'(bus.full), 64'h1);
        press(1, 0, 1, 2'd0, 16'h0055, 1);
        chk("t2.ptr", 64'(bus.ptr), 64'h1);

        // Single clear in manual mode, then clear-all in auto mode.
        press(1, 0, 1, 2'd0, 16'h0066, 1);
        press(1, 0, 1, 2'd0, 16'h0077, 1);
        press(1, 0, 1, 2'd0, 16'h0088, 1);
        press(0, 1, 0, 2'd1, 16'h0, 2);
        chk("t3.loaded", 64'(bus.loaded), 64'hD);
        chk("t3.full",   64'(bus.full),   64'h0);
        press(0, 1, 1, 2'd0, 16'h0, 2);
        chk("t3.operands", bus.operands, 64'h0);

        // Set and clear together with ptr=2: clear wins, ptr returns to 0.
        press(1, 0, 1, 2'd0, 16'h0101, 1);
        press(1, 0, 1, 2'd0, 16'h0202, 1);
        press(1, 1, 1, 2'd0, 16'h0303, 2);
        chk("t4.ptr", 64'(bus.ptr), 64'h0);

        // Mode change retargets the view immediately.
        press(1, 0, 1, 2'd0, 16'h0aaa, 1);
        @(negedge clk);
        cur_mode = 1'b0; cur_sw = 2'd0; bus.mode = 1'b0; bus.sw = 2'd0;
        #1 check_all("mode0");
        cur_mode = 1'b1; bus.mode = 1'b1;
        #1 check_all("mode1");

        // Randomized presses.
        for (int n = 0; n < 40; n++) begin
            bit s, c;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 3) == 0);
            if (!s && !c) s = 1'b1;
            press(s, c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  16'($urandom), $urandom_range(1, 4));
        end

        // Reset during an in-flight press (one and two cycles after the fall).
        for (int d = 1; d <= 2; d++) begin
            press(1, 0, 1, 2'd0, 16'hbeef, 1);
            @(negedge clk);
            cur_mode = 1'b0; cur_sw = 2'd1;
            bus.mode = 1'b0; bus.sw = 2'd1; bus.from_set = 16'hcafe;
            bus.set_n = 1'b0;
            for (int k = 0; k < d; k++) begin
                @(negedge clk);
                bus.set_n = 1'b1;
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk($sformatf("rstflight%0d.wr_stb", d), 64'(bus.wr_stb), 64'h0);
            end
            check_all("rstflight");
        end

        // NUM=3: out-of-range select is inert; in-range works.
        press3(2'd3, 16'habcd, 0, 0, 48'h0);
        press3(2'd2, 16'habcd, 0, 1, 48'habcd_0000_0000);
        press3(2'd3, 16'h0000, 1, 0, 48'habcd_0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_bank.md
Name: operand_bank

Overview:
- Parametrised successor to the two-operand number router.
- Holds NUM operand registers of BITS width internally instead of routing set/reset strobes to external registers.
- Debounced-edge button handshake, switch-selected or auto-sequenced entry, flattened operand bus to the ALU, LED view of the selected operand.
- Sits between the number-entry (setter) block, the board switches/buttons and the ALU operand inputs.

Parameters:
- BITS, 16, width of each operand register.
- NUM, 4, number of operand registers; must be >= 2.
- SEL_W, $clog2(NUM) (2 at default), width of SW and PTR; derived, not overridden.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- SW  input  SEL_W  manual operand select (MODE=0).
- MODE  input  1  0 = manual select, 1 = auto-sequence via PTR.
- SET_N  input  1  raw active-low "load" button, asynchronous to CLK.
- CLR_N  input  1  raw active-low "clear" button, asynchronous to CLK.
- FROM_SET  input  BITS  value from the setter block.
- TO_SET  output  BITS  currently selected operand, fed back to the setter.
- OPERANDS  output  NUM*BITS  all registers flattened; operand i at [i*BITS +: BITS].
- LEDS  output  10  low bits of TO_SET.
- PTR  output  SEL_W  auto-sequence pointer.
- LOADED  output  NUM  per-operand "written since last clear" flags.
- FULL  output  1  high when all LOADED bits are 1.
- WR_STB  output  1  one-cycle pulse after any register write.

Behaviour:
- Reset (RST=1 at a rising edge):
  - All operand registers, LOADED, PTR and WR_STB go to 0.
  - Synchroniser flops go to 1 (buttons released). Hence TO_SET=0, LEDS=0, FULL=0.
  - Reset overrides any pulse in the same cycle and cancels any in-flight button edge.
- Button synchronisation: SET_N and CLR_N each pass through two flops (s1, s2) plus a history flop (s3).
  - A pulse is set_p = s3 & ~s2 (falling edge).
  - A button low at edge k is written at edge k+2; WR_STB is high during the cycle after edge k+2.
  - Holding a button low produces exactly one pulse. Release generates nothing.
- Index: IDX = SW when MODE=0; IDX = PTR when MODE=1.
  - If MODE=0 and SW >= NUM (non-power-of-2 NUM): index invalid. TO_SET=0, LEDS=0, set/clear pulses ignored, no WR_STB.
- TO_SET = REG[IDX], combinational from registers.
- LEDS = TO_SET[9:0]; if BITS < 10, zero-extend.
- set_p only:
  - REG[IDX] <= FROM_SET; LOADED[IDX] <= 1.
  - If MODE=1: PTR <= (PTR == NUM-1) ? 0 : PTR+1 (wrap).
  - Overwriting an already-loaded register is allowed.
- clr_p only, MODE=0: REG[IDX] <= 0; LOADED[IDX] <= 0. PTR unchanged.
- clr_p only, MODE=1: all REG <= 0, LOADED <= 0, PTR <= 0.
- set_p and clr_p in the same cycle: clear action only, no pointer advance.
- WR_STB: pulses for any accepted set or clear.
- FULL = &LOADED. It drops the cycle after any clear.
- MODE change: takes effect on IDX immediately. PTR and registers are retained; no pulse is generated.
- FROM_SET is sampled only on the write edge; no other timing requirement.

Test Plan:
- Reset, then MODE=0, SW=2, FROM_SET=16'h1234, SET_N low 5 cycles -> REG2=1234 at edge 2 after the fall, one WR_STB pulse, LOADED=4'b0100, LEDS=10'h234, FULL=0.
- MODE=1 from PTR=0, four SET_N presses with FROM_SET=0x11,0x22,0x33,0x44 -> OPERANDS=0x0044_0033_0022_0011, PTR wraps to 0, FULL=1; fifth press with 0x55 overwrites REG0=0x55, PTR=1.
- FULL state, MODE=0, SW=1, CLR_N press -> REG1=0, LOADED=4'b1101, FULL=0, PTR unchanged; then MODE=1, CLR_N press -> all registers 0, LOADED=0, PTR=0.
- SET_N and CLR_N fall on the same edge, MODE=1, PTR=2 -> clear-all only, PTR=0, single WR_STB.
- SET_N falls, RST asserted the next cycle -> no write after reset release, all outputs 0, no WR_STB.
- NUM=3 instance, MODE=0, SW=3, SET press with FROM_SET=0xABCD -> no register change, TO_SET=0, LEDS=0, no WR_STB.
